// File: rtl/branch_redirect_unit_if.sv
// Bundles the EX/ID pipeline signals consumed by branch_redirect_unit and the
// PC/hazard controls it produces.
//   master : pipeline side; drives EX/ID info, receives redirect/stall/flush.
//   slave  : branch_redirect_unit side.
// Signals: ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, ex_is_branch,
//   ex_is_jal, ex_is_jalr, ex_funct3, ex_mem_read, ex_rd, id_rs1, id_rs2,
//   id_use_rs1, id_use_rs2 (to unit); branch_flag, jump_flag, branch_address,
//   jump_address, pc_enable, stall_ifid, flush_ifid, flush_idex, squash_ex,
//   target_misaligned, taken_count, stall_count (from unit).
interface branch_redirect_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic [2:0]      ex_funct3;
  logic            ex_mem_read;
  logic [4:0]      ex_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;

  logic            branch_flag;
  logic            jump_flag;
  logic [XLEN-1:0] branch_address;
  logic [XLEN-1:0] jump_address;
  logic            pc_enable;
  logic            stall_ifid;
  logic            flush_ifid;
  logic            flush_idex;
  logic            squash_ex;
  logic            target_misaligned;
  logic [31:0]     taken_count;
  logic [31:0]     stall_count;

  modport master (
    output ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val,
           ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
           ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  branch_flag, jump_flag, branch_address, jump_address,
           pc_enable, stall_ifid, flush_ifid, flush_idex, squash_ex,
           target_misaligned, taken_count, stall_count
  );

  modport slave (
    input  ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val,
           ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
           ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output branch_flag, jump_flag, branch_address, jump_address,
           pc_enable, stall_ifid, flush_ifid, flush_idex, squash_ex,
           target_misaligned, taken_count, stall_count
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// PC-update control for the 5-stage pipeline. Resolves branches/jumps in EX,
// registers the redirect flag + target for the PC register, flushes the two
// wrong-path instructions and squashes EX during the redirect cycle, and
// inserts a one-cycle bubble on load-use hazards.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : branch_redirect_unit_if.slave (EX/ID inputs, PC/stall/flush outputs)
// Optional feature: define BRU_PERF_CNT_EN to build the taken/stall performance
// counters; otherwise taken_count/stall_count are constant zero.
module branch_redirect_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic                   clk,
  input logic                   reset,
  branch_redirect_unit_if.slave bus
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

  logic [0:0]      state;
  logic            branch_flag_q;
  logic            jump_flag_q;
  logic [XLEN-1:0] branch_address_q;
  logic [XLEN-1:0] jump_address_q;
  logic            misaligned_q;

  logic            cond_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] redirect_target;
  logic            redirect_event;
  logic            in_idle;
  logic            capture;
  logic            hazard;
  logic            stall;

  always_comb begin
    cond_taken = 1'b0;
    case (bus.ex_funct3)
      3'b000:  cond_taken = (bus.ex_rs1_val == bus.ex_rs2_val);
      3'b001:  cond_taken = (bus.ex_rs1_val != bus.ex_rs2_val);
      3'b100:  cond_taken = ($signed(bus.ex_rs1_val) <  $signed(bus.ex_rs2_val));
      3'b101:  cond_taken = ($signed(bus.ex_rs1_val) >= $signed(bus.ex_rs2_val));
      3'b110:  cond_taken = (bus.ex_rs1_val <  bus.ex_rs2_val);
      3'b111:  cond_taken = (bus.ex_rs1_val >= bus.ex_rs2_val);
      default: cond_taken = 1'b0;
    endcase
  end

  assign branch_target   = bus.ex_pc + bus.ex_imm;
  assign jalr_sum        = bus.ex_rs1_val + bus.ex_imm;
  assign jump_target     = bus.ex_is_jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                                          : branch_target;
  assign redirect_target = bus.ex_is_branch ? branch_target : jump_target;

  assign redirect_event = bus.ex_valid &
                          ((bus.ex_is_branch & cond_taken) | bus.ex_is_jal | bus.ex_is_jalr);
  assign in_idle        = (state == IDLE);
  assign capture        = in_idle & redirect_event;

  assign hazard = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                  ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                   (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
  // Redirect capture outranks the stall; in REDIRECT EX is wrong-path so no stall.
  assign stall  = in_idle & hazard & ~redirect_event;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      branch_flag_q    <= 1'b0;
      jump_flag_q      <= 1'b0;
      branch_address_q <= '0;
      jump_address_q   <= '0;
      misaligned_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            state         <= REDIRECT;
            branch_flag_q <= bus.ex_is_branch;
            jump_flag_q   <= ~bus.ex_is_branch;
            misaligned_q  <= redirect_target[1];
            if (bus.ex_is_branch) branch_address_q <= branch_target;
            else                  jump_address_q   <= jump_target;
          end
        end
        REDIRECT: begin
          state         <= IDLE;
          branch_flag_q <= 1'b0;
          jump_flag_q   <= 1'b0;
          misaligned_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.branch_flag       = branch_flag_q;
  assign bus.jump_flag         = jump_flag_q;
  assign bus.branch_address    = branch_address_q;
  assign bus.jump_address      = jump_address_q;
  assign bus.target_misaligned = misaligned_q;

  // Controls are forced to their quiet values while reset is held.
  assign bus.pc_enable  = ~reset | ~stall;
  assign bus.stall_ifid = reset & stall;
  assign bus.flush_idex = reset & (stall | (state == REDIRECT));
  assign bus.flush_ifid = reset & (state == REDIRECT);
  assign bus.squash_ex  = reset & (state == REDIRECT);

`ifdef BRU_PERF_CNT_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (capture) taken_cnt_q <= taken_cnt_q + 32'd1;
      if (stall)   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.taken_count = taken_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.taken_count = '0;
  assign bus.stall_count = '0;
`endif

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Control block that drives the PC update stage of the 5-stage pipeline: it resolves branches and jumps in EX, presents the registered `branch_flag`/`jump_flag`/target addresses to the PC register, and generates the PC `enable`, IF/ID stall and stage flush controls. It also detects load-use hazards and inserts a single-cycle bubble.

## Interface
- `XLEN`, 32, datapath and address width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `ex_valid`  in  1  EX holds a real (non-bubble) instruction.
- `ex_pc`  in  XLEN  PC of the EX instruction.
- `ex_imm`  in  XLEN  sign-extended immediate.
- `ex_rs1_val`, `ex_rs2_val`  in  XLEN  forwarded operands.
- `ex_is_branch`, `ex_is_jal`, `ex_is_jalr`  in  1 each  decoded type; at most one set.
- `ex_funct3`  in  3  branch condition.
- `ex_mem_read`  in  1  EX instruction is a load.
- `ex_rd`  in  5  EX destination register.
- `id_rs1`, `id_rs2`  in  5 each  ID source registers.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction reads that source.
- `branch_flag`  out  1  registered; PC loads `branch_address`.
- `jump_flag`  out  1  registered; PC loads `jump_address`.
- `branch_address`, `jump_address`  out  XLEN  registered targets.
- `pc_enable`  out  1  PC register enable.
- `stall_ifid`  out  1  hold IF/ID register.
- `flush_ifid`, `flush_idex`  out  1 each  load bubble into that register.
- `squash_ex`  out  1  EX result must not write back or access memory.
- `target_misaligned`  out  1  registered; redirect target has bit 1 set.
- `taken_count`, `stall_count`  out  32 each  performance counters.

## Operation
- Two-state FSM: IDLE, REDIRECT. Reset state is IDLE.
- Branch condition by `ex_funct3`: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE. 010 and 011 are never taken.
- Targets: branch and JAL use `ex_pc + ex_imm`. JALR uses `(ex_rs1_val + ex_imm) & ~1`. Arithmetic is modulo 2^XLEN, with no overflow detection.
- IDLE: a taken branch, JAL or JALR with `ex_valid=1` is a redirect event.
  - At the clock edge, register the flag and target and go to REDIRECT.
  - Branches use `branch_flag`/`branch_address`. JAL/JALR use `jump_flag`/`jump_address`. Never both.
  - The unused address register holds its previous value.
- REDIRECT lasts exactly 1 cycle:
  - Outputs: flag = 1, `pc_enable=1`, `flush_ifid=1`, `flush_idex=1`, `squash_ex=1`.
  - All EX inputs are wrong-path and ignored; no new redirect or stall is taken.
  - Next state is always IDLE, and the flags drop to 0.
- Load-use hazard, evaluated in IDLE only: `ex_valid & ex_mem_read & ex_rd!=0` and ((`id_use_rs1` & `id_rs1==ex_rd`) or (`id_use_rs2` & `id_rs2==ex_rd`)).
  - Response, combinational in the same cycle: `pc_enable=0`, `stall_ifid=1`, `flush_idex=1`.
- Priority: redirect capture wins over hazard stall. If both are detected in one cycle, do not stall and capture the redirect.
- `target_misaligned` is registered with the redirect when target bit 1 = 1. The redirect still occurs.

## Timing
- Resolution latency: branch in EX at cycle N, flag high in N+1, PC holds the target after the N+1 edge. The branch penalty is 2 fetched wrong-path instructions plus 1 EX squash.
- Reset (`reset=0` at an edge):
  - FSM returns to IDLE.
  - `branch_flag`, `jump_flag`, `target_misaligned` = 0.
  - Addresses = 0; counters = 0.
- Combinational outputs while `reset=0`: `pc_enable=1`, and all stall/flush/squash = 0.
- Reset asserted during REDIRECT aborts the redirect: the flags are 0 on the next cycle.
- Back-to-back: a taken branch in the cycle after REDIRECT (IDLE again) is a new valid redirect.

## Configuration
- `BRU_PERF_CNT_EN` defined:
  - `taken_count` increments on every redirect capture.
  - `stall_count` increments on every load-use stall cycle.
  - Both wrap at 2^32 and clear on reset.
- Not defined: both counters are constant 0 and no counter flops are built.

## Test plan
- BEQ taken: `ex_pc=0x100`, `ex_imm=0x40`, rs1=rs2=5.
  - Next cycle: `branch_flag=1`, `branch_address=0x140`, flush_ifid/flush_idex/squash_ex=1.
  - Cycle after: flag=0.
- BLT vs BLTU with rs1=0xFFFFFFFF, rs2=1: BLT taken, BLTU not taken (flags stay 0).
- JALR with rs1=0x2003, imm=4: `jump_flag=1`, `jump_address=0x2006`, `target_misaligned=1`.
- Load-use: `ex_mem_read=1`, `ex_rd=7`, `id_rs2=7`, `id_use_rs2=1`.
  - Same cycle: `pc_enable=0`, `stall_ifid=1`, `flush_idex=1`.
  - Repeat with `ex_rd=0`: no stall.
- Wrong-path suppression: a taken JAL is captured; during REDIRECT drive another taken branch plus a hazard. No second redirect and no stall.
  - With `BRU_PERF_CNT_EN`: `taken_count=1`.
- Reset mid-REDIRECT: drive `reset=0` in the REDIRECT cycle. Next cycle: flags=0, addresses=0, counters=0, FSM in IDLE.
